// File: rtl/pipeline_debug_controller_pkg.sv
// Shared definitions for the pipeline debug controller: command encodings,
// controller/dump state enums and the default snapshot depth.
package pipeline_debug_pkg;

    localparam int SNAP_WORDS_DEF = 16;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_HALT = 2'b11
    } cmdOpT;

    // DUMP covers both the count word and the latch words; the dump
    // sequencer tracks which of the two is on the wire.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DUMP = 2'd3
    } ctrlStateT;

    typedef enum logic [1:0] {
        DS_IDLE  = 2'd0,
        DS_CNT   = 2'd1,
        DS_WORDS = 2'd2
    } dumpStateT;

    function automatic int addrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipeline_debug_controller_if.sv
// Command and snapshot-transmit handshakes between the debug host side
// and the pipeline debug controller.
interface pipeline_debug_controller_if
    import pipeline_debug_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    cmdOpT             cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, tx_ready,
        input  cmd_ready, tx_valid, tx_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, tx_ready,
        output cmd_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/pipeline_debug_controller_dump_sequencer.sv
// Streams the cycle count followed by SNAP_WORDS latch words over a
// valid/ready link; started by a one-cycle pulse, reports done on the last beat.
module debug_dump_sequencer
    import pipeline_debug_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SNAP_WORDS = SNAP_WORDS_DEF,
    parameter int ADDR_W     = addrWidth(SNAP_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] countIn,
    output logic              done,
    output logic [ADDR_W-1:0] snapAddr,
    input  logic [DATA_W-1:0] snapData,
    output logic              txValid,
    input  logic              txReady,
    output logic [DATA_W-1:0] txData
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SNAP_WORDS - 1);

    dumpStateT         stateReg, stateNext;
    logic [ADDR_W-1:0] addrReg, addrNext;
    logic [DATA_W-1:0] dataReg, dataNext;
    logic              validReg, validNext;
    logic              lastReg, lastNext;
    logic [ADDR_W-1:0] addrBump;

    // snapAddr always points at the word to fetch next, so the word can be
    // loaded on the same edge that retires the current one.
    assign addrBump = (addrReg == LAST_ADDR) ? '0 : addrReg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= DS_IDLE;
            addrReg  <= '0;
            dataReg  <= '0;
            validReg <= 1'b0;
            lastReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            addrReg  <= addrNext;
            dataReg  <= dataNext;
            validReg <= validNext;
            lastReg  <= lastNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        addrNext  = addrReg;
        dataNext  = dataReg;
        validNext = validReg;
        lastNext  = lastReg;
        done      = 1'b0;
        unique case (stateReg)
            DS_IDLE: begin
                if (start) begin
                    stateNext = DS_CNT;
                    validNext = 1'b1;
                    dataNext  = countIn;
                    addrNext  = '0;
                    lastNext  = 1'b0;
                end
            end
            DS_CNT: begin
                if (txReady) begin
                    stateNext = DS_WORDS;
                    dataNext  = snapData;
                    lastNext  = (addrReg == LAST_ADDR);
                    addrNext  = addrBump;
                end
            end
            DS_WORDS: begin
                if (txReady) begin
                    if (lastReg) begin
                        stateNext = DS_IDLE;
                        validNext = 1'b0;
                        done      = 1'b1;
                    end else begin
                        dataNext = snapData;
                        lastNext = (addrReg == LAST_ADDR);
                        addrNext = addrBump;
                    end
                end
            end
            default: stateNext = DS_IDLE;
        endcase
    end

    assign snapAddr = addrReg;
    assign txValid  = validReg;
    assign txData   = dataReg;

endmodule

// File: rtl/pipeline_debug_controller.sv
// Debug-path sequencer for the five-stage pipeline: RUN/STEP/HALT control of
// the shared stop_debug freeze line, executed-cycle counting and snapshot dumps.
module pipeline_debug_controller
    import pipeline_debug_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SNAP_WORDS = SNAP_WORDS_DEF,
    parameter int STEP_W     = 16,
    localparam int ADDR_W    = addrWidth(SNAP_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_debug_controller_if.slave  bus,
    input  logic                        halt_detect,
    output logic                        stop_debug,
    output logic                        halted,
    output logic                        busy,
    output logic [DATA_W-1:0]           cycle_count,
    output logic [ADDR_W-1:0]           snap_addr,
    input  logic [DATA_W-1:0]           snap_data
);
    ctrlStateT         stateReg, stateNext;
    logic [STEP_W-1:0] stepCntReg, stepCntNext;
    logic              haltedReg, haltedNext;
    logic              stopDebugReg;
    logic [DATA_W-1:0] cycleCountReg, cycleCountNext;
    logic              cmdReady, cmdFire, dumpStart, dumpDone;

    assign cmdReady       = (stateReg == ST_IDLE) || (stateReg == ST_RUN);
    assign cmdFire        = bus.cmd_valid && cmdReady;
    assign cycleCountNext = stopDebugReg ? cycleCountReg : cycleCountReg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg      <= ST_IDLE;
            stepCntReg    <= '0;
            haltedReg     <= 1'b0;
            stopDebugReg  <= 1'b1;
            cycleCountReg <= '0;
        end else begin
            stateReg      <= stateNext;
            stepCntReg    <= stepCntNext;
            haltedReg     <= haltedNext;
            stopDebugReg  <= !((stateNext == ST_RUN) || (stateNext == ST_STEP));
            cycleCountReg <= cycleCountNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        stepCntNext = stepCntReg;
        haltedNext  = haltedReg;
        dumpStart   = 1'b0;
        unique case (stateReg)
            ST_IDLE: begin
                if (cmdFire && (bus.cmd_op == CMD_RUN || bus.cmd_op == CMD_STEP)) begin
                    // A finished program is never released again; only re-dumped.
                    if (haltedReg || (bus.cmd_op == CMD_STEP && bus.cmd_arg == '0)) begin
                        stateNext = ST_DUMP;
                        dumpStart = 1'b1;
                    end else if (bus.cmd_op == CMD_RUN) begin
                        stateNext = ST_RUN;
                    end else begin
                        stateNext   = ST_STEP;
                        stepCntNext = bus.cmd_arg;
                    end
                end
            end
            ST_RUN: begin
                if (halt_detect || (cmdFire && bus.cmd_op == CMD_HALT)) begin
                    stateNext  = ST_DUMP;
                    dumpStart  = 1'b1;
                    haltedNext = haltedReg | halt_detect;
                end
            end
            ST_STEP: begin
                stepCntNext = stepCntReg - 1'b1;
                if (halt_detect || stepCntReg == STEP_W'(1)) begin
                    stateNext  = ST_DUMP;
                    dumpStart  = 1'b1;
                    haltedNext = haltedReg | halt_detect;
                end
            end
            ST_DUMP: begin
                if (dumpDone) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // The count is handed over as its post-edge value so the final executed
    // cycle of a RUN/STEP is included in the dumped word.
    debug_dump_sequencer #(
        .DATA_W    (DATA_W),
        .SNAP_WORDS(SNAP_WORDS),
        .ADDR_W    (ADDR_W)
    ) dumpSeq (
        .clk     (clk),
        .rst     (rst),
        .start   (dumpStart),
        .countIn (cycleCountNext),
        .done    (dumpDone),
        .snapAddr(snap_addr),
        .snapData(snap_data),
        .txValid (bus.tx_valid),
        .txReady (bus.tx_ready),
        .txData  (bus.tx_data)
    );

    assign bus.cmd_ready = cmdReady;
    assign stop_debug    = stopDebugReg;
    assign halted        = haltedReg;
    assign busy          = (stateReg != ST_IDLE);
    assign cycle_count   = cycleCountReg;

endmodule

// File: doc/pipeline_debug_controller.md
Name: pipeline_debug_controller

Overview:
- Sequences the five-stage pipeline for the debug path: drives the shared stop_debug freeze line (Execute, Memory and Write-Back latches all honour it) and counts executed cycles.
- Accepts RUN / STEP n / HALT commands and detects program end.
- On every stop, streams a snapshot (cycle count plus SNAP_WORDS latch words) to the debug transmitter over a valid/ready handshake.

Parameters:
- DATA_W, 32, width of snapshot words and cycle counter.
- SNAP_WORDS, 16, number of pipeline-latch words dumped after the cycle count (>=1).
- STEP_W, 16, width of the step-count argument.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT.
- cmd_arg  in  STEP_W  step count for STEP.
- halt_detect  in  1  HALT instruction retired in WB this cycle.
- stop_debug  out  1  1 = pipeline frozen; registered.
- halted  out  1  sticky program-end flag.
- busy  out  1  state != IDLE.
- cycle_count  out  DATA_W  cycles executed with stop_debug=0.
- snap_addr  out  clog2(SNAP_WORDS)  snapshot word select.
- snap_data  in  DATA_W  combinational read of the word at snap_addr.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts.
- tx_data  out  DATA_W  dump word.

Behaviour:
- Reset values:
  - State IDLE; stop_debug=1; halted=0; cycle_count=0; snap_addr=0; tx_valid=0; tx_data=0; internal step counter=0.
  - Reset is asynchronous, so asserting rst mid-operation drops tx_valid immediately.
- States:
  - IDLE: stop_debug=1; cmd_ready=1.
  - RUN: stop_debug=0; cmd_ready=1.
  - STEP: stop_debug=0; cmd_ready=0.
  - DUMP_CNT and DUMP_WORDS: stop_debug=1; cmd_ready=0.
- stop_debug timing: registered from next-state, so it deasserts the cycle after a RUN/STEP accept and reasserts the cycle after stop.
- cycle_count: increments on each posedge where stop_debug=0; wraps at 2^DATA_W.
- Transitions from IDLE:
  - RUN -> RUN.
  - STEP, arg=N>0 -> STEP with counter=N.
  - STEP, arg=0 -> DUMP_CNT.
  - HALT or NOP -> accepted, no effect.
  - If halted=1, RUN and STEP go directly to DUMP_CNT (re-dump); the pipeline is never released.
- Transitions from RUN:
  - halt_detect -> DUMP_CNT, set halted.
  - HALT cmd -> DUMP_CNT.
  - RUN, STEP and NOP cmds are accepted and dropped.
  - HALT cmd together with halt_detect -> single DUMP, halted=1.
- Transitions from STEP:
  - Counter decrements each executed cycle; when counter reaches 0 -> DUMP_CNT.
  - STEP N therefore gives exactly N cycles with stop_debug=0.
  - halt_detect -> DUMP_CNT immediately, halted=1.
  - Counter expiry together with halt_detect -> one dump, halted=1.
- DUMP_CNT:
  - tx_valid=1, tx_data=cycle_count.
  - On tx_ready -> DUMP_WORDS, snap_addr=0.
- DUMP_WORDS:
  - tx_data=snap_data captured on entry and on each advance.
  - tx_data stays stable while tx_valid && !tx_ready.
  - Advance snap_addr on each handshake.
  - Handshake on word SNAP_WORDS-1 -> IDLE, tx_valid=0.
- Throughput: one word per cycle with tx_ready held high. A dump is SNAP_WORDS+1 transfers; tx_valid never deasserts mid-dump except on reset.

Decomposition:
- Shared package (pipeline_debug_pkg):
  - cmd_op encodings CMD_NOP/RUN/STEP/HALT.
  - FSM state enum.
  - SNAP_WORDS default.
- One natural sub-module: debug_dump_sequencer, which covers the DUMP_CNT/DUMP_WORDS handshake, snap_addr counter and tx registers. Started by a pulse, returns done.

Test Plan:
- Reset, then STEP arg=5 -> stop_debug low exactly 5 cycles. Then 17 tx words: first=5, then snap_addr 0..15 in order; state IDLE; halted=0.
- RUN, halt_detect pulsed after 12 executed cycles -> stop_debug reasserts the next cycle; first tx word=12; halted=1; subsequent RUN leaves stop_debug=1 and triggers a re-dump with first word 12.
- RUN, then HALT cmd after 7 cycles; tx_ready toggled 1/0 every cycle -> each word is held stable until handshake, with no word lost or duplicated; 17 transfers total.
- STEP arg=0 -> no cycle executed; dump first word = prior cycle_count; cmd_ready=0 throughout the dump.
- STEP arg=3 with halt_detect on its 3rd cycle -> a single dump, halted=1, cycle_count+3.
- rst asserted mid-DUMP_WORDS (snap_addr=6) -> tx_valid=0, stop_debug=1, cycle_count=0 asynchronously; next STEP 1 works normally.
